ctrl_ext_alu: RTL and testbench
===============================

Name: ctrl_ext_alu

Overview:
Registered decode/execute slice of the single-cycle MIPS datapath. It combines the main control decoder, the 16→32 immediate extender and the ALU. Every output is captured in one output register stage. It takes decoder fields plus register-file operands, and feeds npc, regfile, dm_4k and the write-back mux.

Parameters:
none (datapath fixed at 32 bits; PC word address 30 bits)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
op  in  6  instruction opcode [31:26]
func  in  6  function field [5:0]
shamt  in  5  shift amount [10:6]
imm16  in  16  immediate field
busA  in  32  rs operand
busB  in  32  rt operand
cur_pc  in  30  current PC, word address (byte address = {cur_pc,2'b00})
regWr  out  1  register write enable
regDst  out  1  1 = write rd, 0 = write rt (jal: regfile forces $31)
Extop  out  1  1 = sign-extend, 0 = zero-extend
alusrc  out  1  1 = ALU B is imm32, 0 = busB
aluop  out  5  ALU operation code
memWr  out  1  data-memory write
memtoreg  out  1  1 = write-back from memory
branch  out  1  conditional branch (beq/bne)
jump  out  1  j/jal/jr/jalr
imm32  out  32  extended immediate
result  out  32  ALU result
zero  out  1  result == 0

Behaviour:
- Internal logic is combinational. On rising clk, all outputs load the combinational values together: 1-cycle latency. They hold between edges.
- rst high, at any time and asynchronously: every output becomes 0. While rst is high, clk edges are ignored. After reset deasserts, the first rising edge loads normally.
- Extender: Extop=1 gives {{16{imm16[15]}},imm16}; Extop=0 gives {16'b0,imm16}.
- ALU B operand = alusrc ? imm32 : busB. A = busA.
- aluop codes and results:
  - 0 ADD: A+B, wrap mod 2^32, no overflow trap.
  - 1 SUB: A−B, wrap mod 2^32.
  - 2 AND, 3 OR, 4 XOR, 5 NOR: bitwise.
  - 6 SLT: signed A<B → 1, else 0.
  - 7 SLTU: unsigned A<B → 1, else 0.
  - 8 SLL, 9 SRL, 10 SRA: shift B by shamt.
  - 11 SLLV, 12 SRLV, 13 SRAV: shift B by A[4:0].
  - 14 LUI: {B[15:0],16'b0}.
  - 15 LINK: {cur_pc,2'b00}+4.
  - 16–31: result 0.
- zero = (result == 32'b0), computed on the same-cycle result.
- Control decode (flags not listed are 0):
  - op=0x00 R-type: regWr=1, regDst=1, alusrc=0.
    - func→aluop: 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA; 0x04 SLLV; 0x06 SRLV; 0x07 SRAV.
    - func 0x08 jr: jump=1, regWr=0.
    - func 0x09 jalr: jump=1, regWr=1, regDst=1, aluop=LINK.
    - Other func: regWr=0, aluop=ADD.
  - 0x08 addi / 0x09 addiu: regWr, Extop, alusrc, ADD.
  - 0x0C andi / 0x0D ori / 0x0E xori: regWr, alusrc, Extop=0, AND/OR/XOR.
  - 0x0F lui: regWr, alusrc, LUI.
  - 0x0A slti / 0x0B sltiu: regWr, Extop, alusrc, SLT/SLTU.
  - 0x23 lw: regWr, Extop, alusrc, memtoreg, ADD.
  - 0x2B sw: Extop, alusrc, memWr, ADD.
  - 0x04 beq / 0x05 bne: branch, Extop, alusrc=0, SUB.
  - 0x02 j: jump. 0x03 jal: jump, regWr, regDst=0, LINK.
  - Any other op: all flags 0, aluop=ADD (acts as NOP).
- regDst, memtoreg, Extop and alusrc are don't-care to consumers when unused, but they must match the table exactly.

Test Plan:
- rst pulse mid-cycle while outputs are nonzero → all outputs 0 immediately; the first edge after release loads the current inputs.
- R addu: op=0, func=0x21, busA=0xFFFFFFFF, busB=1 → one edge later result=0, zero=1, regWr=1, regDst=1, aluop=0.
- ori: op=0x0D, imm16=0x8001, busA=0x10 → imm32=0x00008001, result=0x00008011, Extop=0, alusrc=1.
- slti: op=0x0A, busA=0xFFFFFFFE, imm16=0xFFFF → imm32=0xFFFFFFFF, result=1. sltiu with the same inputs → result=1. lw with busA=4, imm16=0xFFFC → result=0, memtoreg=1.
- sra: op=0, func=0x03, busB=0x80000000, shamt=4 → result=0xF8000000. srlv with busA=36 → shift of 4, result=0x08000000.
- jal: op=0x03, cur_pc=0x00000C00 → result=0x00003004, jump=1, regWr=1. beq with busA=busB=7 → branch=1, zero=1. Unknown op 0x3F → all flags 0.

Source files
------------

// File: rtl/ctrl_ext_alu_if.sv
// Bundle of decoder fields, operands and registered control/ALU outputs for ctrl_ext_alu.
// master drives the instruction side and observes results; slave is the execute slice.
interface ctrl_ext_alu_if;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [29:0] cur_pc;
    logic        regWr;
    logic        regDst;
    logic        Extop;
    logic        alusrc;
    logic [4:0]  aluop;
    logic        memWr;
    logic        memtoreg;
    logic        branch;
    logic        jump;
    logic [31:0] imm32;
    logic [31:0] result;
    logic        zero;

    modport master (
        output op, func, shamt, imm16, busA, busB, cur_pc,
        input  regWr, regDst, Extop, alusrc, aluop, memWr, memtoreg, branch, jump,
        input  imm32, result, zero
    );

    modport slave (
        input  op, func, shamt, imm16, busA, busB, cur_pc,
        output regWr, regDst, Extop, alusrc, aluop, memWr, memtoreg, branch, jump,
        output imm32, result, zero
    );
endinterface

// File: rtl/ctrl_ext_alu.sv
// Registered decode/execute slice: main control decoder, immediate extender and ALU,
// with every output captured in a single register stage (1-cycle latency).
module ctrl_ext_alu (
    input  logic         clk,
    input  logic         rst,
    ctrl_ext_alu_if.slave bus
);
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_SLLV = 5'd11;
    localparam logic [4:0] ALU_SRLV = 5'd12;
    localparam logic [4:0] ALU_SRAV = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd14;
    localparam logic [4:0] ALU_LINK = 5'd15;

    logic        w_regWr, w_regDst, w_Extop, w_alusrc;
    logic        w_memWr, w_memtoreg, w_branch, w_jump;
    logic [4:0]  w_aluop;
    logic [31:0] w_imm32, w_b, w_result;

    logic        r_regWr, r_regDst, r_Extop, r_alusrc;
    logic        r_memWr, r_memtoreg, r_branch, r_jump;
    logic [4:0]  r_aluop;
    logic [31:0] r_imm32, r_result;
    logic        r_zero;

    always_comb begin
        w_regWr    = 1'b0;
        w_regDst   = 1'b0;
        w_Extop    = 1'b0;
        w_alusrc   = 1'b0;
        w_aluop    = ALU_ADD;
        w_memWr    = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        case (bus.op)
            6'h00: begin
                w_regWr  = 1'b1;
                w_regDst = 1'b1;
                case (bus.func)
                    6'h20, 6'h21: w_aluop = ALU_ADD;
                    6'h22, 6'h23: w_aluop = ALU_SUB;
                    6'h24: w_aluop = ALU_AND;
                    6'h25: w_aluop = ALU_OR;
                    6'h26: w_aluop = ALU_XOR;
                    6'h27: w_aluop = ALU_NOR;
                    6'h2A: w_aluop = ALU_SLT;
                    6'h2B: w_aluop = ALU_SLTU;
                    6'h00: w_aluop = ALU_SLL;
                    6'h02: w_aluop = ALU_SRL;
                    6'h03: w_aluop = ALU_SRA;
                    6'h04: w_aluop = ALU_SLLV;
                    6'h06: w_aluop = ALU_SRLV;
                    6'h07: w_aluop = ALU_SRAV;
                    6'h08: begin
                        w_jump  = 1'b1;
                        w_regWr = 1'b0;
                    end
                    6'h09: begin
                        w_jump  = 1'b1;
                        w_aluop = ALU_LINK;
                    end
                    default: w_regWr = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                w_regWr  = 1'b1;
                w_Extop  = 1'b1;
                w_alusrc = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_regWr  = 1'b1;
                w_alusrc = 1'b1;
                w_aluop  = (bus.op == 6'h0C) ? ALU_AND :
                           (bus.op == 6'h0D) ? ALU_OR : ALU_XOR;
            end
            6'h0F: begin
                w_regWr  = 1'b1;
                w_alusrc = 1'b1;
                w_aluop  = ALU_LUI;
            end
            6'h0A, 6'h0B: begin
                w_regWr  = 1'b1;
                w_Extop  = 1'b1;
                w_alusrc = 1'b1;
                w_aluop  = (bus.op == 6'h0A) ? ALU_SLT : ALU_SLTU;
            end
            6'h23: begin
                w_regWr    = 1'b1;
                w_Extop    = 1'b1;
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
            end
            6'h2B: begin
                w_Extop  = 1'b1;
                w_alusrc = 1'b1;
                w_memWr  = 1'b1;
            end
            6'h04, 6'h05: begin
                w_branch = 1'b1;
                w_Extop  = 1'b1;
                w_aluop  = ALU_SUB;
            end
            6'h02: w_jump = 1'b1;
            6'h03: begin
                w_jump  = 1'b1;
                w_regWr = 1'b1;
                w_aluop = ALU_LINK;
            end
            default: ;
        endcase
    end

    assign w_imm32 = w_Extop ? {{16{bus.imm16[15]}}, bus.imm16} : {16'b0, bus.imm16};
    assign w_b     = w_alusrc ? w_imm32 : bus.busB;

    always_comb begin
        w_result = 32'b0;
        case (w_aluop)
            ALU_ADD:  w_result = bus.busA + w_b;
            ALU_SUB:  w_result = bus.busA - w_b;
            ALU_AND:  w_result = bus.busA & w_b;
            ALU_OR:   w_result = bus.busA | w_b;
            ALU_XOR:  w_result = bus.busA ^ w_b;
            ALU_NOR:  w_result = ~(bus.busA | w_b);
            ALU_SLT:  w_result = {31'b0, $signed(bus.busA) < $signed(w_b)};
            ALU_SLTU: w_result = {31'b0, bus.busA < w_b};
            ALU_SLL:  w_result = w_b << bus.shamt;
            ALU_SRL:  w_result = w_b >> bus.shamt;
            ALU_SRA:  w_result = $signed(w_b) >>> bus.shamt;
            ALU_SLLV: w_result = w_b << bus.busA[4:0];
            ALU_SRLV: w_result = w_b >> bus.busA[4:0];
            ALU_SRAV: w_result = $signed(w_b) >>> bus.busA[4:0];
            ALU_LUI:  w_result = {w_b[15:0], 16'b0};
            ALU_LINK: w_result = {bus.cur_pc, 2'b00} + 32'd4;
            default:  w_result = 32'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regWr    <= 1'b0;
            r_regDst   <= 1'b0;
            r_Extop    <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 5'd0;
            r_memWr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_jump     <= 1'b0;
            r_imm32    <= 32'b0;
            r_result   <= 32'b0;
            r_zero     <= 1'b0;
        end else begin
            r_regWr    <= w_regWr;
            r_regDst   <= w_regDst;
            r_Extop    <= w_Extop;
            r_alusrc   <= w_alusrc;
            r_aluop    <= w_aluop;
            r_memWr    <= w_memWr;
            r_memtoreg <= w_memtoreg;
            r_branch   <= w_branch;
            r_jump     <= w_jump;
            r_imm32    <= w_imm32;
            r_result   <= w_result;
            r_zero     <= (w_result == 32'b0);
        end
    end

    assign bus.regWr    = r_regWr;
    assign bus.regDst   = r_regDst;
    assign bus.Extop    = r_Extop;
    assign bus.alusrc   = r_alusrc;
    assign bus.aluop    = r_aluop;
    assign bus.memWr    = r_memWr;
    assign bus.memtoreg = r_memtoreg;
    assign bus.branch   = r_branch;
    assign bus.jump     = r_jump;
    assign bus.imm32    = r_imm32;
    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_ctrl_ext_alu.sv
// Directed-vector bench for ctrl_ext_alu; control flags are compared as one packed vector
// {regWr,regDst,Extop,alusrc,aluop[4:0],memWr,memtoreg,branch,jump}.
module tb_ctrl_ext_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ctrl_ext_alu_if bus ();

    ctrl_ext_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic rw, input logic rd, input logic ex,
                                       input logic src, input logic [4:0] op,
                                       input logic mw, input logic m2r,
                                       input logic br, input logic j);
        return {rw, rd, ex, src, op, mw, m2r, br, j};
    endfunction

    function automatic logic [12:0] ctl_now();
        return {bus.regWr, bus.regDst, bus.Extop, bus.alusrc, bus.aluop,
                bus.memWr, bus.memtoreg, bus.branch, bus.jump};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] func, input logic [4:0] shamt,
                         input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input logic [29:0] pc);
        bus.op = op; bus.func = func; bus.shamt = shamt; bus.imm16 = imm;
        bus.busA = a; bus.busB = b; bus.cur_pc = pc;
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] func, input logic [4:0] shamt,
                        input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                        input logic [29:0] pc);
        @(negedge clk);
        drive(op, func, shamt, imm, a, b, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(6'h00, 6'h21, 5'd0, 16'h1234, 32'h1, 32'h2, 30'h0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ctl_now(), bus.imm32, bus.result, bus.zero} !== 78'b0) begin
            n_errors++;
            $display("FAIL reset_initial: got ctl=%h imm32=%h result=%h zero=%b, want all 0",
                     ctl_now(), bus.imm32, bus.result, bus.zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.result !== 32'h3 || ctl_now() !== mk(1,1,0,0,5'd0,0,0,0,0)) begin
            n_errors++;
            $display("FAIL reset_first_load: got result=%h ctl=%h, want result=00000003 ctl=%h",
                     bus.result, ctl_now(), mk(1,1,0,0,5'd0,0,0,0,0));
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ctl_now(), bus.imm32, bus.result, bus.zero} !== 78'b0) begin
            n_errors++;
            $display("FAIL reset_async: got ctl=%h imm32=%h result=%h, want all 0",
                     ctl_now(), bus.imm32, bus.result);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.result !== 32'h0 || bus.regWr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: got result=%h regWr=%b with rst high, want 0", bus.result, bus.regWr);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'h10, 32'h20, 30'h0);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.result !== 32'h30 || bus.zero !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_load: got result=%h zero=%b, want 00000030 0", bus.result, bus.zero);
        end
    endtask

    task automatic test_rtype();
        step(6'h00, 6'h21, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1, 30'h0);
        n_checks++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || ctl_now() !== mk(1,1,0,0,5'd0,0,0,0,0)) begin
            n_errors++;
            $display("FAIL addu: got result=%h zero=%b ctl=%h, want 00000000 1 %h",
                     bus.result, bus.zero, ctl_now(), mk(1,1,0,0,5'd0,0,0,0,0));
        end
        step(6'h00, 6'h27, 5'd0, 16'h0, 32'h0F0F0000, 32'h000000FF, 30'h0);
        n_checks++;
        if (bus.result !== 32'hF0F0FF00 || bus.aluop !== 5'd5) begin
            n_errors++;
            $display("FAIL nor: got result=%h aluop=%0d, want f0f0ff00 5", bus.result, bus.aluop);
        end
        step(6'h00, 6'h2A, 5'd0, 16'h0, 32'h80000000, 32'h1, 30'h0);
        n_checks++;
        if (bus.result !== 32'h1 || bus.aluop !== 5'd6) begin
            n_errors++;
            $display("FAIL slt_r: got result=%h aluop=%0d, want 00000001 6", bus.result, bus.aluop);
        end
        step(6'h00, 6'h3F, 5'd0, 16'h0, 32'h5, 32'h6, 30'h0);
        n_checks++;
        if (bus.result !== 32'hB || ctl_now() !== mk(0,1,0,0,5'd0,0,0,0,0)) begin
            n_errors++;
            $display("FAIL rtype_unknown_func: got result=%h ctl=%h, want 0000000b %h",
                     bus.result, ctl_now(), mk(0,1,0,0,5'd0,0,0,0,0));
        end
    endtask

    task automatic test_immediate();
        step(6'h0D, 6'h00, 5'd0, 16'h8001, 32'h10, 32'hDEAD, 30'h0);
        n_checks++;
        if (bus.imm32 !== 32'h00008001 || bus.result !== 32'h00008011 ||
            ctl_now() !== mk(1,0,0,1,5'd3,0,0,0,0)) begin
            n_errors++;
            $display("FAIL ori: got imm32=%h result=%h ctl=%h, want 00008001 00008011 %h",
                     bus.imm32, bus.result, ctl_now(), mk(1,0,0,1,5'd3,0,0,0,0));
        end
        step(6'h0A, 6'h00, 5'd0, 16'hFFFF, 32'hFFFFFFFE, 32'h0, 30'h0);
        n_checks++;
        if (bus.imm32 !== 32'hFFFFFFFF || bus.result !== 32'h1 || ctl_now() !== mk(1,0,1,1,5'd6,0,0,0,0)) begin
            n_errors++;
            $display("FAIL slti: got imm32=%h result=%h ctl=%h, want ffffffff 00000001 %h",
                     bus.imm32, bus.result, ctl_now(), mk(1,0,1,1,5'd6,0,0,0,0));
        end
        step(6'h0B, 6'h00, 5'd0, 16'hFFFF, 32'hFFFFFFFE, 32'h0, 30'h0);
        n_checks++;
        if (bus.result !== 32'h1 || bus.aluop !== 5'd7) begin
            n_errors++;
            $display("FAIL sltiu: got result=%h aluop=%0d, want 00000001 7", bus.result, bus.aluop);
        end
        step(6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h4, 32'h0, 30'h0);
        n_checks++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || ctl_now() !== mk(1,0,1,1,5'd0,0,1,0,0)) begin
            n_errors++;
            $display("FAIL lw: got result=%h zero=%b ctl=%h, want 00000000 1 %h",
                     bus.result, bus.zero, ctl_now(), mk(1,0,1,1,5'd0,0,1,0,0));
        end
        step(6'h2B, 6'h00, 5'd0, 16'h0008, 32'h100, 32'h0, 30'h0);
        n_checks++;
        if (bus.result !== 32'h108 || ctl_now() !== mk(0,0,1,1,5'd0,1,0,0,0)) begin
            n_errors++;
            $display("FAIL sw: got result=%h ctl=%h, want 00000108 %h",
                     bus.result, ctl_now(), mk(0,0,1,1,5'd0,1,0,0,0));
        end
        step(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hFFFF, 32'h0, 30'h0);
        n_checks++;
        if (bus.imm32 !== 32'h00001234 || bus.result !== 32'h12340000 || ctl_now() !== mk(1,0,0,1,5'd14,0,0,0,0)) begin
            n_errors++;
            $display("FAIL lui: got imm32=%h result=%h ctl=%h, want 00001234 12340000 %h",
                     bus.imm32, bus.result, ctl_now(), mk(1,0,0,1,5'd14,0,0,0,0));
        end
    endtask

    task automatic test_shift();
        step(6'h00, 6'h03, 5'd4, 16'h0, 32'h0, 32'h80000000, 30'h0);
        n_checks++;
        if (bus.result !== 32'hF8000000 || bus.aluop !== 5'd10) begin
            n_errors++;
            $display("FAIL sra: got result=%h aluop=%0d, want f8000000 10", bus.result, bus.aluop);
        end
        step(6'h00, 6'h06, 5'd0, 16'h0, 32'd36, 32'h80000000, 30'h0);
        n_checks++;
        if (bus.result !== 32'h08000000 || bus.aluop !== 5'd12) begin
            n_errors++;
            $display("FAIL srlv: got result=%h aluop=%0d, want 08000000 12", bus.result, bus.aluop);
        end
        step(6'h00, 6'h00, 5'd31, 16'h0, 32'h0, 32'h3, 30'h0);
        n_checks++;
        if (bus.result !== 32'h80000000 || bus.aluop !== 5'd8) begin
            n_errors++;
            $display("FAIL sll31: got result=%h aluop=%0d, want 80000000 8", bus.result, bus.aluop);
        end
        step(6'h00, 6'h07, 5'd0, 16'h0, 32'h8, 32'h80000000, 30'h0);
        n_checks++;
        if (bus.result !== 32'hFF800000) begin
            n_errors++;
            $display("FAIL srav: got result=%h, want ff800000", bus.result);
        end
    endtask

    task automatic test_control_flow();
        step(6'h03, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0, 30'h00000C00);
        n_checks++;
        if (bus.result !== 32'h00003004 || ctl_now() !== mk(1,0,0,0,5'd15,0,0,0,1)) begin
            n_errors++;
            $display("FAIL jal: got result=%h ctl=%h, want 00003004 %h",
                     bus.result, ctl_now(), mk(1,0,0,0,5'd15,0,0,0,1));
        end
        step(6'h00, 6'h09, 5'd0, 16'h0, 32'h0, 32'h0, 30'h3FFFFFFF);
        n_checks++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || ctl_now() !== mk(1,1,0,0,5'd15,0,0,0,1)) begin
            n_errors++;
            $display("FAIL jalr_wrap: got result=%h zero=%b ctl=%h, want 00000000 1 %h",
                     bus.result, bus.zero, ctl_now(), mk(1,1,0,0,5'd15,0,0,0,1));
        end
        step(6'h00, 6'h08, 5'd0, 16'h0, 32'h40, 32'h0, 30'h0);
        n_checks++;
        if (bus.jump !== 1'b1 || bus.regWr !== 1'b0 || bus.branch !== 1'b0) begin
            n_errors++;
            $display("FAIL jr: got jump=%b regWr=%b branch=%b, want 1 0 0", bus.jump, bus.regWr, bus.branch);
        end
        step(6'h04, 6'h00, 5'd0, 16'h0010, 32'h7, 32'h7, 30'h0);
        n_checks++;
        if (bus.zero !== 1'b1 || bus.imm32 !== 32'h10 || ctl_now() !== mk(0,0,1,0,5'd1,0,0,1,0)) begin
            n_errors++;
            $display("FAIL beq: got zero=%b imm32=%h ctl=%h, want 1 00000010 %h",
                     bus.zero, bus.imm32, ctl_now(), mk(0,0,1,0,5'd1,0,0,1,0));
        end
        step(6'h05, 6'h00, 5'd0, 16'h0, 32'h7, 32'h8, 30'h0);
        n_checks++;
        if (bus.zero !== 1'b0 || bus.result !== 32'hFFFFFFFF || bus.branch !== 1'b1) begin
            n_errors++;
            $display("FAIL bne: got zero=%b result=%h branch=%b, want 0 ffffffff 1",
                     bus.zero, bus.result, bus.branch);
        end
        step(6'h02, 6'h00, 5'd0, 16'h0, 32'h1, 32'h1, 30'h0);
        n_checks++;
        if (ctl_now() !== mk(0,0,0,0,5'd0,0,0,0,1)) begin
            n_errors++;
            $display("FAIL j: got ctl=%h, want %h", ctl_now(), mk(0,0,0,0,5'd0,0,0,0,1));
        end
        step(6'h3F, 6'h21, 5'd0, 16'h8000, 32'h2, 32'h3, 30'h0);
        n_checks++;
        if (ctl_now() !== 13'b0 || bus.imm32 !== 32'h00008000 || bus.result !== 32'h5) begin
            n_errors++;
            $display("FAIL unknown_op: got ctl=%h imm32=%h result=%h, want 0000 00008000 00000005",
                     ctl_now(), bus.imm32, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        step(6'h08, 6'h00, 5'd0, 16'h0001, 32'h7FFFFFFF, 32'h0, 30'h0);
        n_checks++;
        if (bus.result !== 32'h80000000 || ctl_now() !== mk(1,0,1,1,5'd0,0,0,0,0)) begin
            n_errors++;
            $display("FAIL b2b_addi: got result=%h ctl=%h, want 80000000 %h",
                     bus.result, ctl_now(), mk(1,0,1,1,5'd0,0,0,0,0));
        end
        @(negedge clk);
        drive(6'h0E, 6'h00, 5'd0, 16'hFFFF, 32'hFFFF0000, 32'h0, 30'h0);
        #1;
        n_checks++;
        if (bus.result !== 32'h80000000 || bus.aluop !== 5'd0) begin
            n_errors++;
            $display("FAIL b2b_hold: got result=%h aluop=%0d before edge, want 80000000 0",
                     bus.result, bus.aluop);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.result !== 32'hFFFFFFFF || bus.imm32 !== 32'h0000FFFF || ctl_now() !== mk(1,0,0,1,5'd4,0,0,0,0)) begin
            n_errors++;
            $display("FAIL b2b_xori: got result=%h imm32=%h ctl=%h, want ffffffff 0000ffff %h",
                     bus.result, bus.imm32, ctl_now(), mk(1,0,0,1,5'd4,0,0,0,0));
        end
        step(6'h0C, 6'h00, 5'd0, 16'h00F0, 32'h0F0F0F0F, 32'h0, 30'h0);
        n_checks++;
        if (bus.result !== 32'h00000000 || bus.zero !== 1'b1 || bus.aluop !== 5'd2) begin
            n_errors++;
            $display("FAIL b2b_andi: got result=%h zero=%b aluop=%0d, want 00000000 1 2",
                     bus.result, bus.zero, bus.aluop);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_immediate();
        test_shift();
        test_control_flow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
